seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_hex_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the seven-segment scan driver.
//                Segment patterns are active-low, packed as {g,f,e,d,c,b,a}.
//  Revision    : 1.0
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] c_SEG_0   = 7'b1000000;
    localparam logic [6:0] c_SEG_1   = 7'b1111001;
    localparam logic [6:0] c_SEG_2   = 7'b0100100;
    localparam logic [6:0] c_SEG_3   = 7'b0110000;
    localparam logic [6:0] c_SEG_4   = 7'b0011001;
    localparam logic [6:0] c_SEG_5   = 7'b0010010;
    localparam logic [6:0] c_SEG_6   = 7'b0000010;
    localparam logic [6:0] c_SEG_7   = 7'b1111000;
    localparam logic [6:0] c_SEG_8   = 7'b0000000;
    localparam logic [6:0] c_SEG_9   = 7'b0010000;
    localparam logic [6:0] c_SEG_A   = 7'b0001000;
    localparam logic [6:0] c_SEG_B   = 7'b0000011;
    localparam logic [6:0] c_SEG_C   = 7'b1000110;
    localparam logic [6:0] c_SEG_D   = 7'b0100001;
    localparam logic [6:0] c_SEG_E   = 7'b0000110;
    localparam logic [6:0] c_SEG_F   = 7'b0001110;
    localparam logic [6:0] c_SEG_OFF = 7'b1111111;

    // One complete set of display contents: digits, points and enables.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } disp_set_t;

    function automatic logic [NUM_DIGITS-1:0] digit_select(input logic [2:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex nibble to active-low segment decoder.
//  Revision    : 1.0
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_OFF;
        case (i_hex)
            4'h0: o_seg = c_SEG_0;
            4'h1: o_seg = c_SEG_1;
            4'h2: o_seg = c_SEG_2;
            4'h3: o_seg = c_SEG_3;
            4'h4: o_seg = c_SEG_4;
            4'h5: o_seg = c_SEG_5;
            4'h6: o_seg = c_SEG_6;
            4'h7: o_seg = c_SEG_7;
            4'h8: o_seg = c_SEG_8;
            4'h9: o_seg = c_SEG_9;
            4'hA: o_seg = c_SEG_A;
            4'hB: o_seg = c_SEG_B;
            4'hC: o_seg = c_SEG_C;
            4'hD: o_seg = c_SEG_D;
            4'hE: o_seg = c_SEG_E;
            4'hF: o_seg = c_SEG_F;
            default: o_seg = c_SEG_OFF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Eight-digit multiplexed seven-segment driver with
//                frame-synchronous (tear-free) update of the displayed value.
//                Optional macro SEG7_BLANK_LEADING_ZERO_EN blanks leading zeros.
//  Revision    : 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV = 100000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        pending,
    output logic        frame_done,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [7:0]  AN
);

    localparam int                 c_CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic               r_frame_done;
    logic               r_pending;
    disp_set_t          r_pend_set;
    disp_set_t          r_disp_set;
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tick;
    logic               w_wrap;
    logic [2:0]         w_idx_next;
    disp_set_t          w_capture;
    disp_set_t          w_disp_next;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic               w_blank;
    logic               w_lit;

    assign w_tick     = (r_cnt == c_CNT_MAX);
    assign w_wrap     = w_tick && (r_idx == 3'd7);
    assign w_idx_next = r_idx + 3'd1;
    assign w_capture  = {data, dp, digit_en};

    // The set used for the upcoming digit: a load landing exactly on the
    // frame boundary wins over anything still pending.
    always_comb begin
        w_disp_next = r_disp_set;
        if (w_wrap) begin
            if (load) begin
                w_disp_next = w_capture;
            end else if (r_pending) begin
                w_disp_next = r_pend_set;
            end
        end
    end

    assign w_nib = w_disp_next.data[{w_idx_next, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .i_hex (w_nib),
        .o_seg (w_seg_dec)
    );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    logic [NUM_DIGITS-1:0] w_nz_above;
    logic                  w_seen;

    // w_nz_above[k]: some enabled digit at position k or higher is non-zero.
    always_comb begin
        w_nz_above = '0;
        w_seen     = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_seen        = w_seen | (w_disp_next.en[k] && (w_disp_next.data[4*k +: 4] != 4'h0));
            w_nz_above[k] = w_seen;
        end
    end

    assign w_blank = (w_idx_next != 3'd0) && !w_nz_above[w_idx_next];
`else
    assign w_blank = 1'b0;
`endif

    assign w_lit = w_disp_next.en[w_idx_next] && !w_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_idx_next;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 1'b0;
            r_pend_set <= '0;
            r_disp_set <= '0;
        end else begin
            r_disp_set <= w_disp_next;
            if (load && !w_wrap) begin
                r_pend_set <= w_capture;
                r_pending  <= 1'b1;
            end else if (w_wrap) begin
                r_pending  <= 1'b0;
            end
        end
    end

    // Outputs only move on a tick, so they stay dark from reset to the first tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 8'hFF;
            r_seg <= c_SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            if (w_lit) begin
                r_an  <= digit_select(w_idx_next);
                r_seg <= w_seg_dec;
                r_dp  <= ~w_disp_next.dp[w_idx_next];
            end else begin
                r_an  <= 8'hFF;
                r_seg <= c_SEG_OFF;
                r_dp  <= 1'b1;
            end
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign AN         = r_an;
    assign DP         = r_dp;
    assign CA         = r_seg[0];
    assign CB         = r_seg[1];
    assign CC         = r_seg[2];
    assign CD         = r_seg[3];
    assign CE         = r_seg[4];
    assign CF         = r_seg[5];
    assign CG         = r_seg[6];

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench for seg7_scan_driver at DIV = 4.
//  Revision    : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0]  AN;
    logic [6:0]  seg_obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIV(DIV)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp         (dp),
        .digit_en   (digit_en),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .CA         (CA),
        .CB         (CB),
        .CC         (CC),
        .CD         (CD),
        .CE         (CE),
        .CF         (CF),
        .CG         (CG),
        .DP         (DP),
        .AN         (AN)
    );

    // Observed segments in a..g order, left to right.
    assign seg_obs = {CA, CB, CC, CD, CE, CF, CG};

    function automatic logic [6:0] exp_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        data     = d;
        dp       = p;
        digit_en = e;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        data     = 32'hDEADBEEF;
        dp       = 8'hAA;
        digit_en = 8'h55;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 80);
        chk_eq(tag, {31'd0, frame_done}, 32'd1);
    endtask

    task automatic check_digit(input string tag, input logic [7:0] an_e,
                               input logic [6:0] seg_e, input logic dp_e);
        chk_eq({tag, "_an"},  {24'd0, AN},      {24'd0, an_e});
        chk_eq({tag, "_seg"}, {25'd0, seg_obs}, {25'd0, seg_e});
        chk_eq({tag, "_dp"},  {31'd0, DP},      {31'd0, dp_e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  an_e;
        logic        lit;

        rst_n    = 1'b0;
        load     = 1'b0;
        data     = '0;
        dp       = '0;
        digit_en = '0;

        // Reset state
        step(3);
        check_digit("rst", 8'hFF, 7'h7F, 1'b1);
        chk_eq("rst_pend", {31'd0, pending}, 32'd0);
        chk_eq("rst_fd",   {31'd0, frame_done}, 32'd0);
        #2 rst_n = 1'b1;
        step(1);
        check_digit("pretick", 8'hFF, 7'h7F, 1'b1);

        // Scan of 1234ABCD with all digits enabled
        d = 32'h1234ABCD;
        do_load(d, 8'h00, 8'hFF);
        chk_eq("scan_pend", {31'd0, pending}, 32'd1);
        wait_frame("scan_wrap");
        chk_eq("scan_pend0", {31'd0, pending}, 32'd0);
        check_digit("scan0", 8'hFE, 7'b1000010, 1'b1);
        for (int k = 1; k < 8; k++) begin
            step(4);
            an_e = ~(8'b1 << k);
            check_digit($sformatf("scan%0d", k), an_e, exp_seg(d[4*k +: 4]), 1'b1);
            chk_eq($sformatf("scan_fd%0d", k), {31'd0, frame_done}, 32'd0);
        end
        step(4);
        chk_eq("scan_period", {31'd0, frame_done}, 32'd1);
        chk_eq("scan_an_wrap", {24'd0, AN}, 32'h000000FE);
        step(1);
        chk_eq("scan_pulse", {31'd0, frame_done}, 32'd0);

        // Mid-frame load must not tear the current frame
        do_load(32'h00000000, 8'h00, 8'hFF);
        chk_eq("tear_pend", {31'd0, pending}, 32'd1);
        check_digit("tear_hold0", 8'hFE, 7'b1000010, 1'b1);
        step(2);
        for (int k = 1; k < 8; k++) begin
            if (k > 1) step(4);
            an_e = ~(8'b1 << k);
            check_digit($sformatf("tear%0d", k), an_e, exp_seg(d[4*k +: 4]), 1'b1);
            chk_eq($sformatf("tear_pend%0d", k), {31'd0, pending}, 32'd1);
        end
        step(4);
        chk_eq("tear_wrap", {31'd0, frame_done}, 32'd1);
        check_digit("tear_new0", 8'hFE, 7'b0000001, 1'b1);
        chk_eq("tear_pend_clr", {31'd0, pending}, 32'd0);

        // Load coinciding with the 7->0 boundary
        step(31);
        chk_eq("coin_pre_pend", {31'd0, pending}, 32'd0);
        do_load(32'h89ABCDEF, 8'h00, 8'hFF);
        chk_eq("coin_wrap", {31'd0, frame_done}, 32'd1);
        chk_eq("coin_pend", {31'd0, pending}, 32'd0);
        check_digit("coin0", 8'hFE, 7'b0111000, 1'b1);
        step(1);
        chk_eq("coin_pend_b", {31'd0, pending}, 32'd0);
        step(3);
        check_digit("coin1", 8'hFD, 7'b0110000, 1'b1);

        // Digit masking and decimal points
        d = 32'h76543210;
        do_load(d, 8'h01, 8'h0F);
        wait_frame("mask_wrap");
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(4);
            lit  = (k < 4);
            an_e = lit ? ~(8'b1 << k) : 8'hFF;
            check_digit($sformatf("mask%0d", k), an_e,
                        lit ? exp_seg(d[4*k +: 4]) : 7'h7F, (k == 0) ? 1'b0 : 1'b1);
        end

        // Leading zeros: blanked only when the option is built in
        d = 32'h00000305;
        do_load(d, 8'hFF, 8'hFF);
        wait_frame("blank_wrap");
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(4);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
            lit = (k <= 2);
`else
            lit = 1'b1;
`endif
            an_e = lit ? ~(8'b1 << k) : 8'hFF;
            check_digit($sformatf("blank%0d", k), an_e,
                        lit ? exp_seg(d[4*k +: 4]) : 7'h7F, lit ? 1'b0 : 1'b1);
        end

        // Reset mid-frame discards the pending value
        do_load(32'hFFFFFFFF, 8'hFF, 8'hFF);
        chk_eq("mrst_pend_pre", {31'd0, pending}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_digit("mrst", 8'hFF, 7'h7F, 1'b1);
        chk_eq("mrst_pend", {31'd0, pending}, 32'd0);
        chk_eq("mrst_fd",   {31'd0, frame_done}, 32'd0);
        #10 rst_n = 1'b1;
        wait_frame("mrst_wrap");
        check_digit("mrst_after", 8'hFF, 7'h7F, 1'b1);
        chk_eq("mrst_pend_after", {31'd0, pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
